// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port VRAM between the sprite pixel fetcher (SPR), the
// background line fetcher (BG) and the CPU/Avalon bridge (CPU). At most one
// access is issued per cycle. Every read carries a requester tag through a
// fixed-latency pipeline, so the returned data can be steered back to the
// requester that issued it.
//
// The priority policy depends on the video phase:
//   active video : SPR > BG > CPU, but a CPU request that has waited
//                  CPU_WAIT_MAX cycles is forced through once.
//   vblank       : CPU > BG > SPR.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   vblank                     vertical blanking indicator
//   spr_req/addr/gnt/rvalid    sprite read port
//   bg_req/addr/gnt/rvalid     background read port
//   cpu_req/we/addr/wdata/gnt/rvalid  CPU read/write port
//   rdata                      shared read-return bus (registered)
//   mem_addr/rd/wr/wdata       registered VRAM command
//   mem_rdata                  VRAM read data, valid RD_LAT cycles after mem_rd
//
// gnt outputs are combinational: a gnt means the request is captured on the
// coming clock edge. The access appears on mem_* in the next cycle, and a read
// produces its rvalid RD_LAT+2 cycles after its gnt.
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = 2,
  parameter int CPU_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  // sprite fetcher
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_gnt,
  output logic              spr_rvalid,
  // background fetcher
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_gnt,
  output logic              bg_rvalid,
  // CPU bridge
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  // shared read return
  output logic [DATA_W-1:0] rdata,
  // VRAM
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    S_ACTIVE = 1'b0,
    S_VBLANK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SPR  = 2'd1,
    TAG_BG   = 2'd2,
    TAG_CPU  = 2'd3
  } tag_e;

  localparam int                WAIT_W    = $clog2(CPU_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(CPU_WAIT_MAX);
  // One stage per memory-latency cycle plus the command register stage.
  localparam int                TAG_DEPTH = RD_LAT + 1;

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  tag_e                tag_q [TAG_DEPTH];

  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                spr_rvalid_q, bg_rvalid_q, cpu_rvalid_q;

  tag_e                grant_tag;
  logic                grant_wr;
  logic [ADDR_W-1:0]   grant_addr;

  // ---------------------------------------------------------------------------
  // Arbitration. The policy comes from the registered state, so a vblank edge
  // only changes the order from the following cycle on.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    spr_gnt = 1'b0;
    bg_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    if (state_q == S_VBLANK) begin
      if      (cpu_req) cpu_gnt = 1'b1;
      else if (bg_req)  bg_gnt  = 1'b1;
      else if (spr_req) spr_gnt = 1'b1;
    end else begin
      // A starved CPU request jumps the queue exactly once.
      if      (cpu_req && wait_q == WAIT_MAX) cpu_gnt = 1'b1;
      else if (spr_req)                       spr_gnt = 1'b1;
      else if (bg_req)                        bg_gnt  = 1'b1;
      else if (cpu_req)                       cpu_gnt = 1'b1;
    end
  end

  // Starvation counter: counts cycles a CPU request is refused during active
  // video, saturating; any grant, dropped request or vblank clears it.
  always_comb begin
    wait_d = '0;
    if (state_q == S_ACTIVE && cpu_req && !cpu_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    end
  end

  // Command mux for the granted requester. Writes carry no tag.
  always_comb begin
    grant_tag  = TAG_NONE;
    grant_wr   = 1'b0;
    grant_addr = cpu_addr;
    if (spr_gnt) begin
      grant_tag  = TAG_SPR;
      grant_addr = spr_addr;
    end else if (bg_gnt) begin
      grant_tag  = TAG_BG;
      grant_addr = bg_addr;
    end else if (cpu_gnt) begin
      grant_tag  = cpu_we ? TAG_NONE : TAG_CPU;
      grant_wr   = cpu_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Policy state machine and starvation counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= S_ACTIVE;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        S_ACTIVE: if (vblank)  state_q <= S_VBLANK;
        S_VBLANK: if (!vblank) state_q <= S_ACTIVE;
        default:               state_q <= S_ACTIVE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered VRAM command, read-tag pipeline and read return.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      spr_rvalid_q <= 1'b0;
      bg_rvalid_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      // NOTE: the tag pipeline is reset even though it is array storage: a
      // stale tag surviving reset would fire a spurious rvalid afterwards.
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= TAG_NONE;
    end else begin
      mem_rd_q <= (grant_tag != TAG_NONE);
      mem_wr_q <= grant_wr;
      // Address and write data hold their last values on idle cycles.
      if (spr_gnt || bg_gnt || cpu_gnt) mem_addr_q <= grant_addr;
      if (grant_wr) mem_wdata_q <= cpu_wdata;

      tag_q[0] <= grant_tag;
      for (int i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];

      // The oldest tag lines up with mem_rdata of the read it belongs to.
      if (tag_q[TAG_DEPTH-1] != TAG_NONE) rdata_q <= mem_rdata;
      spr_rvalid_q <= (tag_q[TAG_DEPTH-1] == TAG_SPR);
      bg_rvalid_q  <= (tag_q[TAG_DEPTH-1] == TAG_BG);
      cpu_rvalid_q <= (tag_q[TAG_DEPTH-1] == TAG_CPU);
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata      = rdata_q;
  assign spr_rvalid = spr_rvalid_q;
  assign bg_rvalid  = bg_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// A behavioural model (integer wait count, queue of pending read returns)
// predicts grants, the VRAM command stream and the tagged read returns.
// A small VRAM model returns a fixed function of the address RD_LAT cycles
// after mem_rd.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;
  localparam int WMAX   = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vblank = 1'b0;
  logic          spr_req = 1'b0, bg_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] spr_addr = '0, bg_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          spr_gnt, bg_gnt, cpu_gnt;
  logic          spr_rvalid, bg_rvalid, cpu_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CPU_WAIT_MAX(WMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // VRAM model: data appears RD_LAT cycles after the mem_rd cycle; any other
  // cycle shows a junk pattern so a mistimed capture is visible.
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic          rd_pipe   [RD_LAT];
  logic [AW-1:0] addr_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0]   <= mem_rd;
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i]   <= rd_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  assign mem_rdata = (rd_pipe[RD_LAT-1] === 1'b1) ? data_of(addr_pipe[RD_LAT-1]) : 16'hDEAD;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Requester IDs: 0 none, 1 SPR, 2 BG, 3 CPU.
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          retq[$];
  int            cyc;
  bit            m_vb;     // policy in force this cycle (vblank seen last cycle)
  int            m_wc;     // CPU wait count
  bit            m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_who;    // model grant of the last stepped cycle
  int            g_who;    // DUT grant of the last stepped cycle

  task automatic model_reset();
    m_vb    = 1'b0;
    m_wc    = 0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    retq.delete();
  endtask

  // Called right after a falling edge with the inputs for this cycle applied.
  // Checks the cycle, advances the model, and returns on the next falling edge.
  task automatic step();
    int   who;
    int   exp_rv;
    ret_t r;
    #1;
    who = 0;
    if (!m_vb) begin
      if (cpu_req && m_wc == WMAX) who = 3;
      else if (spr_req)            who = 1;
      else if (bg_req)             who = 2;
      else if (cpu_req)            who = 3;
    end else begin
      if (cpu_req)      who = 3;
      else if (bg_req)  who = 2;
      else if (spr_req) who = 1;
    end

    check("gnt", {29'b0, cpu_gnt, bg_gnt, spr_gnt}, (who == 0) ? 0 : (1 << (who - 1)));
    check("mem_rd", {31'b0, mem_rd}, {31'b0, m_rd});
    check("mem_wr", {31'b0, mem_wr}, {31'b0, m_wr});
    check("mem_addr", {16'b0, mem_addr}, {16'b0, m_addr});
    check("mem_wdata", {16'b0, mem_wdata}, {16'b0, m_wdata});

    exp_rv = 0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      r = retq.pop_front();
      exp_rv = 1 << (r.who - 1);
      check("rdata", {16'b0, rdata}, {16'b0, r.data});
    end
    check("rvalid", {29'b0, cpu_rvalid, bg_rvalid, spr_rvalid}, exp_rv);

    g_who = spr_gnt ? 1 : bg_gnt ? 2 : cpu_gnt ? 3 : 0;

    m_rd = 1'b0;
    m_wr = 1'b0;
    case (who)
      1: begin
        m_rd = 1'b1; m_addr = spr_addr;
        retq.push_back(ret_t'{cyc + RD_LAT + 2, 1, data_of(spr_addr)});
      end
      2: begin
        m_rd = 1'b1; m_addr = bg_addr;
        retq.push_back(ret_t'{cyc + RD_LAT + 2, 2, data_of(bg_addr)});
      end
      3: begin
        m_addr = cpu_addr;
        if (cpu_we) begin
          m_wr = 1'b1; m_wdata = cpu_wdata;
        end else begin
          m_rd = 1'b1;
          retq.push_back(ret_t'{cyc + RD_LAT + 2, 3, data_of(cpu_addr)});
        end
      end
      default: ;
    endcase

    if (m_vb)                      m_wc = 0;
    else if (cpu_req && who != 3)  m_wc = (m_wc < WMAX) ? m_wc + 1 : WMAX;
    else                           m_wc = 0;
    m_vb  = vblank;
    m_who = who;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drop_all();
    spr_req = 1'b0; bg_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_mem_rd"}, {31'b0, mem_rd}, 0);
    check({pfx, "_mem_wr"}, {31'b0, mem_wr}, 0);
    check({pfx, "_mem_addr"}, {16'b0, mem_addr}, 0);
    check({pfx, "_mem_wdata"}, {16'b0, mem_wdata}, 0);
    check({pfx, "_rdata"}, {16'b0, rdata}, 0);
    check({pfx, "_rvalid"}, {29'b0, cpu_rvalid, bg_rvalid, spr_rvalid}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n_spr, n_bg, n_cpu, cpu_at;

    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single sprite read.
    spr_req = 1'b1; spr_addr = 16'h0040;
    step();
    check("t1_spr_gnt", g_who, 1);
    drop_all();
    repeat (6) step();

    // All three requesting in active video: the CPU breaks through once.
    n_spr = 0; n_bg = 0; n_cpu = 0; cpu_at = -1;
    spr_req = 1'b1; spr_addr = 16'h0100;
    bg_req  = 1'b1; bg_addr  = 16'h0200;
    cpu_req = 1'b1; cpu_addr = 16'h0300; cpu_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      case (g_who)
        1: n_spr++;
        2: n_bg++;
        3: begin n_cpu++; cpu_at = i; end
        default: ;
      endcase
    end
    check("t2_spr_cnt", n_spr, 19);
    check("t2_bg_cnt", n_bg, 0);
    check("t2_cpu_cnt", n_cpu, 1);
    check("t2_cpu_at", cpu_at, 15);
    drop_all();
    repeat (6) step();

    // Vblank: old order for one more cycle, then CPU first, then BG.
    vblank = 1'b1;
    spr_req = 1'b1; bg_req = 1'b1; cpu_req = 1'b1;
    step();
    check("t3_edge_gnt", g_who, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_cpu_gnt", g_who, 3);
    end
    cpu_req = 1'b0;
    step();
    check("t3_bg_gnt", g_who, 2);
    drop_all();
    vblank = 1'b0;
    repeat (8) step();

    // CPU write: one-cycle mem_wr with address and data, no read return.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'hBEEF;
    step();
    drop_all();
    check("t4_mem_wr", {31'b0, mem_wr}, 1);
    check("t4_mem_addr", {16'b0, mem_addr}, 32'h1234);
    check("t4_mem_wdata", {16'b0, mem_wdata}, 32'hBEEF);
    repeat (6) step();

    // Alternating SPR / BG reads return in issue order.
    for (int i = 0; i < 4; i++) begin
      spr_req = (i % 2 == 0);
      bg_req  = (i % 2 != 0);
      spr_addr = 16'($urandom);
      bg_addr  = 16'($urandom);
      step();
    end
    drop_all();
    repeat (8) step();

    // Reset while two reads are in flight.
    spr_req = 1'b1; spr_addr = 16'h0A0A;
    step();
    spr_req = 1'b0; bg_req = 1'b1; bg_addr = 16'h0B0B;
    step();
    drop_all();
    rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) step();

    // Randomized traffic with occasional vblank changes.
    for (int n = 0; n < 800; n++) begin
      if (!spr_req && $urandom_range(0, 3) != 0) begin
        spr_req = 1'b1; spr_addr = 16'($urandom);
      end
      if (!bg_req && $urandom_range(0, 1) != 0) begin
        bg_req = 1'b1; bg_addr = 16'($urandom);
      end
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_addr = 16'($urandom);
        cpu_we = ($urandom_range(0, 2) == 0);
        cpu_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 59) == 0) vblank = ~vblank;
      step();
      case (m_who)
        1: spr_req = 1'b0;
        2: bg_req  = 1'b0;
        3: begin cpu_req = 1'b0; cpu_we = 1'b0; end
        default: ;
      endcase
    end
    drop_all();
    vblank = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port VRAM between three requesters: the sprite pixel fetcher (SPR), the background line fetcher that fills the BG FIFO (BG), and the CPU/Avalon bridge (CPU).
- Issues at most one memory access per cycle.
- Tags each read and routes the read data back to the requester that issued it, after a fixed memory latency.
- Switches priority policy between active video and vertical blanking, and has a CPU anti-starvation timer.

Parameters:
- ADDR_W, 16, VRAM word address width.
- DATA_W, 16, VRAM data width.
- RD_LAT, 2, VRAM read latency in cycles, from registered mem_rd to valid mem_rdata (legal range 1..4).
- CPU_WAIT_MAX, 15, maximum cycles a CPU request waits during active video before it is forced through.

Ports:
- clk  in  1  system clock (clk_sys).
- rst_n  in  1  asynchronous active-low reset.
- vblank  in  1  high during vertical blanking; from pixel_counter.
- spr_req  in  1  sprite read request.
- spr_addr  in  ADDR_W  sprite read address.
- spr_gnt  out  1  sprite request accepted this cycle.
- spr_rvalid  out  1  spr_rdata valid.
- bg_req  in  1  background read request.
- bg_addr  in  ADDR_W  background read address.
- bg_gnt  out  1  background request accepted.
- bg_rvalid  out  1  bg_rdata valid.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU access is a write (1) or read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU request accepted.
- cpu_rvalid  out  1  cpu_rdata valid (reads only).
- rdata  out  DATA_W  shared read-return bus; registered copy of mem_rdata.
- mem_addr  out  ADDR_W  VRAM address, registered.
- mem_rd  out  1  VRAM read strobe, registered.
- mem_wr  out  1  VRAM write strobe, registered.
- mem_wdata  out  DATA_W  VRAM write data, registered.
- mem_rdata  in  DATA_W  VRAM read data.

Behaviour:
- Reset: every registered output is 0, the tag pipeline is cleared, the wait counter is 0, and the policy state is S_ACTIVE.
  - Reset asserted mid-operation discards in-flight reads; no rvalid is produced for them after reset.
- Request handshake:
  - A requester holds req, addr and data stable until it sees gnt.
  - gnt is combinational, is at most one-hot, and means the access is captured on this clock edge.
  - The requester may change or drop req in the cycle after gnt.
  - Back-to-back grants to the same requester are allowed, one per cycle.
- Access timing:
  - The granted access appears on mem_* in the cycle after gnt, as a single-cycle strobe.
  - For a read, a tag holding the requester ID enters an RD_LAT+1 deep shift register.
  - When the tag exits, rdata is driven and the matching rvalid pulses for one cycle.
  - Total read latency is RD_LAT+2 cycles from gnt to rvalid.
  - Writes produce no tag and no rvalid.
- Policy state machine:
  - S_ACTIVE moves to S_VBLANK when vblank=1.
  - S_VBLANK moves to S_ACTIVE when vblank=0.
  - Each transition takes effect for arbitration in the cycle after the vblank change.
- S_ACTIVE priority:
  - Normal order is SPR > BG > CPU.
  - The wait counter increments each cycle that cpu_req=1 and cpu_gnt=0, saturating at CPU_WAIT_MAX.
  - When the counter equals CPU_WAIT_MAX, CPU has top priority for the next arbitration.
  - The counter clears on cpu_gnt or when cpu_req=0.
- S_VBLANK priority:
  - Order is CPU > BG > SPR.
  - The wait counter is held at 0.
- Simultaneous events:
  - All three requesting at once: exactly one gnt, chosen by the current order.
  - vblank edge in the same cycle as requests: the old order still applies in that cycle.
- Idle cycles: mem_rd=0 and mem_wr=0; mem_addr and mem_wdata hold their last values.
- Width and ordering:
  - No address arithmetic is performed; addresses pass through unchanged.
  - Read returns are in issue order, because the memory has fixed latency.

Test Plan:
- Reset, then single SPR read at addr 0x0040, RD_LAT=2 -> spr_gnt in cycle 0; mem_rd=1 with mem_addr=0x0040 in cycle 1; spr_rvalid=1 with rdata=mem_rdata in cycle 4; no other rvalid.
- S_ACTIVE with all three requesting continuously for 20 cycles -> SPR granted every cycle except cycle 15, where CPU is granted once when the counter reaches 15; BG gets 0 grants.
- vblank=1 with all requesting -> from the second cycle onward cpu_gnt every cycle; drop cpu_req -> bg_gnt next cycle.
- CPU write with cpu_we=1, addr 0x1234, wdata 0xBEEF -> mem_wr=1 with 0x1234/0xBEEF one cycle after gnt; no cpu_rvalid.
- Alternating SPR/BG grants over 4 consecutive cycles -> rvalids return in the same SPR, BG, SPR, BG order, each RD_LAT+2 cycles after its gnt, with the correct data per tag.
- Assert rst_n low 1 cycle after two reads are granted -> all outputs 0 immediately; no rvalid is seen after reset is released.
